// File: rtl/mnacid_valve_sequencer.sv
// Valve/pump sequencer for the three-lane nucleic-acid purification chip.
// Optional MNACID_SEQ_STEP_EN adds a `step` input that gates every SETTLE exit.
module mnacid_valve_sequencer #(
    parameter int PUMP_PHASE_CYCLES = 4,
    parameter int LOAD_CYCLES       = 64,
    parameter int LYSIS_STROKES     = 8,
    parameter int WASH_STROKES      = 8,
    parameter int ELUTE_STROKES     = 4,
    parameter int COLLECT_STROKES   = 4,
    parameter int SETTLE_CYCLES     = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
`ifdef MNACID_SEQ_STEP_EN
    input  logic       step,
`endif
    output logic       lysis_ctl,
    output logic       wash_ctl,
    output logic       elute_ctl,
    output logic       horiz_ctl,
    output logic       dead_end_ctl,
    output logic       loop_exit_ctl,
    output logic       bead_vtl_ctl,
    output logic       collection_ctl,
    output logic       vertical_ctl,
    output logic       bead_trap_ctl,
    output logic       pump1,
    output logic       pump2,
    output logic       pump3,
    output logic       busy,
    output logic       done,
    output logic       aborted,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_LYSIS   = 3'd2,
        S_WASH    = 3'd3,
        S_ELUTE   = 3'd4,
        S_COLLECT = 3'd5,
        S_SETTLE  = 3'd6,
        S_ABORT   = 3'd7
    } state_t;

    localparam int V_LYSIS   = 9;
    localparam int V_WASH    = 8;
    localparam int V_ELUTE   = 7;
    localparam int V_HORIZ   = 6;
    localparam int V_DEAD    = 5;
    localparam int V_LOOPX   = 4;
    localparam int V_BEADVTL = 3;
    localparam int V_COLL    = 2;
    localparam int V_VERT    = 1;
    localparam int V_TRAP    = 0;

    localparam logic [15:0] PHASE_LAST  = 16'(PUMP_PHASE_CYCLES - 1);
    localparam logic [15:0] LOAD_LAST   = 16'(LOAD_CYCLES - 1);
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);

    state_t      state_q, state_d, next_q, next_d, tgt;
    logic [15:0] cyc_q, cyc_d, stroke_q, stroke_d;
    logic [2:0]  phase_q, phase_d;
    logic [9:0]  valves_q;
    logic [2:0]  pumps_q;
    logic        busy_q, done_q, done_d, aborted_q, aborted_d;
    logic        settle_go;

`ifdef MNACID_SEQ_STEP_EN
    assign settle_go = step;
`else
    assign settle_go = 1'b1;
`endif

    function automatic logic stage_en(input state_t s);
        case (s)
            S_LOAD:    return LOAD_CYCLES != 0;
            S_LYSIS:   return LYSIS_STROKES != 0;
            S_WASH:    return WASH_STROKES != 0;
            S_ELUTE:   return ELUTE_STROKES != 0;
            S_COLLECT: return COLLECT_STROKES != 0;
            default:   return 1'b0;
        endcase
    endfunction

    // First enabled stage at or after code s; IDLE when the protocol is exhausted.
    function automatic state_t first_from(input logic [2:0] s);
        state_t r;
        r = S_IDLE;
        for (int k = 5; k >= 1; k--) begin
            if (3'(k) >= s && stage_en(state_t'(3'(k))))
                r = state_t'(3'(k));
        end
        return r;
    endfunction

    function automatic logic [15:0] strokes_last(input state_t s);
        case (s)
            S_LYSIS:   return 16'(LYSIS_STROKES - 1);
            S_WASH:    return 16'(WASH_STROKES - 1);
            S_ELUTE:   return 16'(ELUTE_STROKES - 1);
            default:   return 16'(COLLECT_STROKES - 1);
        endcase
    endfunction

    function automatic logic [9:0] valve_mask(input state_t s);
        logic [9:0] v;
        v = '1;
        case (s)
            S_LOAD: begin
                v[V_HORIZ] = 1'b0; v[V_DEAD] = 1'b0;
            end
            S_LYSIS: begin
                v[V_LYSIS] = 1'b0; v[V_VERT] = 1'b0; v[V_LOOPX] = 1'b0;
            end
            S_WASH: begin
                v[V_WASH] = 1'b0; v[V_VERT] = 1'b0; v[V_BEADVTL] = 1'b0; v[V_TRAP] = 1'b0;
            end
            S_ELUTE: begin
                v[V_ELUTE] = 1'b0; v[V_VERT] = 1'b0; v[V_BEADVTL] = 1'b0; v[V_TRAP] = 1'b0;
            end
            S_COLLECT: begin
                v[V_BEADVTL] = 1'b0; v[V_TRAP] = 1'b0; v[V_COLL] = 1'b0;
            end
            default: v = '1;
        endcase
        return v;
    endfunction

    function automatic logic [2:0] pump_pat(input logic [2:0] p);
        case (p)
            3'd0:    return 3'b110;
            3'd1:    return 3'b010;
            3'd2:    return 3'b011;
            3'd3:    return 3'b001;
            3'd4:    return 3'b101;
            3'd5:    return 3'b100;
            default: return 3'b111;
        endcase
    endfunction

    function automatic logic is_pump(input state_t s);
        return (s >= S_LYSIS) && (s <= S_COLLECT);
    endfunction

    always_comb begin
        state_d   = state_q;
        next_d    = next_q;
        cyc_d     = cyc_q;
        stroke_d  = stroke_q;
        phase_d   = phase_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        tgt       = first_from(3'(S_LOAD));
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (tgt == S_IDLE) begin
                        done_d = 1'b1;
                    end else begin
                        state_d  = tgt;
                        cyc_d    = '0;
                        stroke_d = '0;
                        phase_d  = '0;
                    end
                end
            end
            S_LOAD: begin
                if (cyc_q == LOAD_LAST) begin
                    state_d = S_SETTLE;
                    next_d  = first_from(3'(S_LYSIS));
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + 16'd1;
                end
            end
            S_LYSIS, S_WASH, S_ELUTE, S_COLLECT: begin
                if (cyc_q != PHASE_LAST) begin
                    cyc_d = cyc_q + 16'd1;
                end else begin
                    cyc_d = '0;
                    if (phase_q != 3'd5) begin
                        phase_d = phase_q + 3'd1;
                    end else begin
                        phase_d = '0;
                        if (stroke_q == strokes_last(state_q)) begin
                            state_d = S_SETTLE;
                            next_d  = first_from(state_q + 3'd1);
                        end else begin
                            stroke_d = stroke_q + 16'd1;
                        end
                    end
                end
            end
            S_SETTLE: begin
                if (cyc_q != SETTLE_LAST) begin
                    cyc_d = cyc_q + 16'd1;
                end else if (settle_go) begin
                    if (next_q == S_IDLE) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d  = next_q;
                        cyc_d    = '0;
                        stroke_d = '0;
                        phase_d  = '0;
                    end
                end
            end
            S_ABORT: begin
                if (cyc_q != SETTLE_LAST) begin
                    cyc_d = cyc_q + 16'd1;
                end else begin
                    state_d   = S_IDLE;
                    aborted_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Abort overrides any same-cycle stage completion.
        if (abort && state_q != S_IDLE && state_q != S_ABORT) begin
            state_d = S_ABORT;
            cyc_d   = '0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            next_q    <= S_IDLE;
            cyc_q     <= '0;
            stroke_q  <= '0;
            phase_q   <= '0;
            valves_q  <= '1;
            pumps_q   <= 3'b111;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            next_q    <= next_d;
            cyc_q     <= cyc_d;
            stroke_q  <= stroke_d;
            phase_q   <= phase_d;
            valves_q  <= valve_mask(state_d);
            pumps_q   <= is_pump(state_d) ? pump_pat(phase_d) : 3'b111;
            busy_q    <= (state_d != S_IDLE);
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    assign lysis_ctl      = valves_q[V_LYSIS];
    assign wash_ctl       = valves_q[V_WASH];
    assign elute_ctl      = valves_q[V_ELUTE];
    assign horiz_ctl      = valves_q[V_HORIZ];
    assign dead_end_ctl   = valves_q[V_DEAD];
    assign loop_exit_ctl  = valves_q[V_LOOPX];
    assign bead_vtl_ctl   = valves_q[V_BEADVTL];
    assign collection_ctl = valves_q[V_COLL];
    assign vertical_ctl   = valves_q[V_VERT];
    assign bead_trap_ctl  = valves_q[V_TRAP];
    assign pump1          = pumps_q[2];
    assign pump2          = pumps_q[1];
    assign pump3          = pumps_q[0];
    assign busy           = busy_q;
    assign done           = done_q;
    assign aborted        = aborted_q;
    assign state          = state_q;

endmodule

// File: tb/tb_mnacid_valve_sequencer.sv
// Directed, table-driven bench for mnacid_valve_sequencer with short protocol timing.
module tb_mnacid_valve_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0, abort = 1'b0;
    logic start2 = 1'b0, abort2 = 1'b0;
`ifdef MNACID_SEQ_STEP_EN
    logic step = 1'b1;
`endif

    logic lysis_ctl, wash_ctl, elute_ctl, horiz_ctl, dead_end_ctl, loop_exit_ctl;
    logic bead_vtl_ctl, collection_ctl, vertical_ctl, bead_trap_ctl;
    logic pump1, pump2, pump3, busy, done, aborted;
    logic [2:0] state;

    logic b_lys, b_wash, b_elu, b_hor, b_dead, b_loop, b_bvtl, b_coll, b_vert, b_trap;
    logic b_p1, b_p2, b_p3, b_busy, b_done, b_abt;
    logic [2:0] b_state;

    always #5 clk = ~clk;

    mnacid_valve_sequencer #(
        .PUMP_PHASE_CYCLES(2), .LOAD_CYCLES(4), .LYSIS_STROKES(1), .WASH_STROKES(1),
        .ELUTE_STROKES(1), .COLLECT_STROKES(1), .SETTLE_CYCLES(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
`ifdef MNACID_SEQ_STEP_EN
        .step(step),
`endif
        .lysis_ctl(lysis_ctl), .wash_ctl(wash_ctl), .elute_ctl(elute_ctl),
        .horiz_ctl(horiz_ctl), .dead_end_ctl(dead_end_ctl), .loop_exit_ctl(loop_exit_ctl),
        .bead_vtl_ctl(bead_vtl_ctl), .collection_ctl(collection_ctl),
        .vertical_ctl(vertical_ctl), .bead_trap_ctl(bead_trap_ctl),
        .pump1(pump1), .pump2(pump2), .pump3(pump3),
        .busy(busy), .done(done), .aborted(aborted), .state(state)
    );

    mnacid_valve_sequencer #(
        .PUMP_PHASE_CYCLES(2), .LOAD_CYCLES(4), .LYSIS_STROKES(1), .WASH_STROKES(0),
        .ELUTE_STROKES(1), .COLLECT_STROKES(1), .SETTLE_CYCLES(3)
    ) dut_skip (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2),
`ifdef MNACID_SEQ_STEP_EN
        .step(step),
`endif
        .lysis_ctl(b_lys), .wash_ctl(b_wash), .elute_ctl(b_elu),
        .horiz_ctl(b_hor), .dead_end_ctl(b_dead), .loop_exit_ctl(b_loop),
        .bead_vtl_ctl(b_bvtl), .collection_ctl(b_coll),
        .vertical_ctl(b_vert), .bead_trap_ctl(b_trap),
        .pump1(b_p1), .pump2(b_p2), .pump3(b_p3),
        .busy(b_busy), .done(b_done), .aborted(b_abt), .state(b_state)
    );

    typedef struct {
        int         t;
        logic [2:0] st;
        logic [9:0] vlv;
        logic [2:0] pmp;
        logic       busy;
        logic       done;
        logic       abt;
    } vec_t;

    vec_t vecs[$];
    int nvec = 0;
    int nfail = 0;

    localparam logic [9:0] M_ALL  = 10'b1111111111;
    localparam logic [9:0] M_LOAD = 10'b1110011111;
    localparam logic [9:0] M_LYS  = 10'b0111101101;
    localparam logic [9:0] M_WASH = 10'b1011110100;
    localparam logic [9:0] M_ELU  = 10'b1101110100;
    localparam logic [9:0] M_COL  = 10'b1111110010;

    logic [2:0] ppat [6] = '{3'b110, 3'b010, 3'b011, 3'b001, 3'b101, 3'b100};

    function automatic logic [18:0] obs();
        return {state, lysis_ctl, wash_ctl, elute_ctl, horiz_ctl, dead_end_ctl, loop_exit_ctl,
                bead_vtl_ctl, collection_ctl, vertical_ctl, bead_trap_ctl,
                pump1, pump2, pump3, busy, done, aborted};
    endfunction

    function automatic void add(int t, logic [2:0] st, logic [9:0] v, logic [2:0] p,
                                logic b, logic d, logic a);
        vec_t e;
        e.t = t; e.st = st; e.vlv = v; e.pmp = p; e.busy = b; e.done = d; e.abt = a;
        vecs.push_back(e);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_vecs_at(input int t);
        foreach (vecs[i]) begin
            if (vecs[i].t == t)
                check($sformatf("vec t=%0d", t), 32'(obs()),
                      32'({vecs[i].st, vecs[i].vlv, vecs[i].pmp,
                           vecs[i].busy, vecs[i].done, vecs[i].abt}));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full protocol run from IDLE, comparing against the vector table.
    task automatic run_table();
        int busy_cnt;
        busy_cnt = 0;
        check_vecs_at(0);
        start = 1'b1;
        for (int t = 1; t <= 69; t++) begin
            tick();
            if (t == 1) start = 1'b0;
            if (busy) busy_cnt++;
            check_vecs_at(t);
        end
        check("busy_cycles", 32'(busy_cnt), 32'd67);
    endtask

    initial begin
        add(0, 3'd0, M_ALL, 3'b111, 1'b0, 1'b0, 1'b0);
        add(1, 3'd1, M_LOAD, 3'b111, 1'b1, 1'b0, 1'b0);
        add(4, 3'd1, M_LOAD, 3'b111, 1'b1, 1'b0, 1'b0);
        add(5, 3'd6, M_ALL, 3'b111, 1'b1, 1'b0, 1'b0);
        add(7, 3'd6, M_ALL, 3'b111, 1'b1, 1'b0, 1'b0);
        for (int t = 8; t <= 19; t++)
            add(t, 3'd2, M_LYS, ppat[(t - 8) / 2], 1'b1, 1'b0, 1'b0);
        add(20, 3'd6, M_ALL, 3'b111, 1'b1, 1'b0, 1'b0);
        add(23, 3'd3, M_WASH, 3'b110, 1'b1, 1'b0, 1'b0);
        add(34, 3'd3, M_WASH, 3'b100, 1'b1, 1'b0, 1'b0);
        add(35, 3'd6, M_ALL, 3'b111, 1'b1, 1'b0, 1'b0);
        add(38, 3'd4, M_ELU, 3'b110, 1'b1, 1'b0, 1'b0);
        add(49, 3'd4, M_ELU, 3'b100, 1'b1, 1'b0, 1'b0);
        add(50, 3'd6, M_ALL, 3'b111, 1'b1, 1'b0, 1'b0);
        add(53, 3'd5, M_COL, 3'b110, 1'b1, 1'b0, 1'b0);
        add(64, 3'd5, M_COL, 3'b100, 1'b1, 1'b0, 1'b0);
        add(65, 3'd6, M_ALL, 3'b111, 1'b1, 1'b0, 1'b0);
        add(67, 3'd6, M_ALL, 3'b111, 1'b1, 1'b0, 1'b0);
        add(68, 3'd0, M_ALL, 3'b111, 1'b0, 1'b1, 1'b0);
        add(69, 3'd0, M_ALL, 3'b111, 1'b0, 1'b0, 1'b0);

        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        run_table();
        tick();

        // Abort in the third WASH cycle.
        start = 1'b1;
        for (int t = 1; t <= 30; t++) begin
            tick();
            if (t == 1) start = 1'b0;
            if (t == 25) begin
                check("wash_c3_state", 32'(state), 32'd3);
                check("wash_c3_pumps", 32'({pump1, pump2, pump3}), 32'(3'b010));
                abort = 1'b1;
            end
            if (t == 26) abort = 1'b0;
            if (t >= 26 && t <= 28)
                check($sformatf("abort t=%0d", t), 32'(obs()),
                      32'({3'd7, M_ALL, 3'b111, 1'b1, 1'b0, 1'b0}));
            if (t == 29)
                check("abort_end", 32'(obs()), 32'({3'd0, M_ALL, 3'b111, 1'b0, 1'b0, 1'b1}));
            if (t == 30)
                check("abort_pulse_end", 32'(aborted), 32'd0);
        end

        // Asynchronous reset in the middle of ELUTE, then a complete rerun.
        start = 1'b1;
        for (int t = 1; t <= 40; t++) begin
            tick();
            if (t == 1) start = 1'b0;
        end
        check("elute_state", 32'(state), 32'd4);
        #2 rst_n = 1'b0;
        #1 check("async_reset", 32'(obs()), 32'({3'd0, M_ALL, 3'b111, 1'b0, 1'b0, 1'b0}));
        tick();
        rst_n = 1'b1;
        tick();
        run_table();
        tick();

        // start and abort together in IDLE: start wins; then abort out of LOAD.
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("start_over_abort", 32'({state, busy}), 32'({3'd1, 1'b1}));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_from_load", 32'(obs()), 32'({3'd7, M_ALL, 3'b111, 1'b1, 1'b0, 1'b0}));
        tick();
        tick();
        tick();
        check("abort_from_load_end", 32'({state, busy, done, aborted}),
              32'({3'd0, 1'b0, 1'b0, 1'b1}));

        // Zero-stroke WASH stage must be skipped together with its SETTLE.
        begin
            logic [2:0] seq[$];
            logic [2:0] exp_seq[9] = '{3'd1, 3'd6, 3'd2, 3'd6, 3'd4, 3'd6, 3'd5, 3'd6, 3'd0};
            logic [2:0] last;
            int seen3, dones, done_t;
            seen3 = 0; dones = 0; done_t = 0;
            last = b_state;
            start2 = 1'b1;
            for (int t = 1; t <= 70; t++) begin
                tick();
                if (t == 1) start2 = 1'b0;
                if (b_state != last) seq.push_back(b_state);
                last = b_state;
                if (b_state == 3'd3) seen3++;
                if (b_done) begin dones++; done_t = t; end
            end
            check("skip_seq_len", 32'(seq.size()), 32'd9);
            for (int i = 0; i < 9; i++)
                check($sformatf("skip_seq[%0d]", i),
                      32'(i < seq.size() ? seq[i] : 3'bxxx), 32'(exp_seq[i]));
            check("skip_no_wash", 32'(seen3), 32'd0);
            check("skip_done_count", 32'(dones), 32'd1);
            check("skip_done_time", 32'(done_t), 32'd53);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/mnacid_valve_sequencer.md
# mnacid_valve_sequencer

Electronic control-side sequencer for the three-lane nucleic-acid purification chip. It generates every pneumatic control line and the three-phase peristaltic pump drive the fluidic netlist consumes. A single `start` runs the protocol load → lysis → wash → elute → collect, with an all-closed settle interval between stages. Outputs are registered and wired directly to the off-chip solenoid drivers.

## Interface
- `PUMP_PHASE_CYCLES`, default 4: clock cycles per pump phase (≥1); one stroke is 6 phases.
- `LOAD_CYCLES`, default 64: duration of LOAD (no pumping).
- `LYSIS_STROKES`, default 8: pump strokes in LYSIS.
- `WASH_STROKES`, default 8: pump strokes in WASH.
- `ELUTE_STROKES`, default 4: pump strokes in ELUTE.
- `COLLECT_STROKES`, default 4: pump strokes in COLLECT.
- `SETTLE_CYCLES`, default 16: all-closed guard interval after each stage (≥1).
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin protocol; sampled in IDLE only.
- `abort` in 1: terminate run safely.
- `lysis_ctl`, `wash_ctl`, `elute_ctl`, `horiz_ctl`, `dead_end_ctl`, `loop_exit_ctl`, `bead_vtl_ctl`, `collection_ctl`, `vertical_ctl`, `bead_trap_ctl` out 1 each: valve control lines; 1 = pressurised = closed.
- `pump1`, `pump2`, `pump3` out 1 each: pump valve controls; 1 = closed.
- `busy` out 1: run in progress.
- `done` out 1: one-cycle pulse on normal completion.
- `aborted` out 1: one-cycle pulse on abort completion.
- `state` out 3: current state code.

## Operation
- States and codes: IDLE=0, LOAD=1, LYSIS=2, WASH=3, ELUTE=4, COLLECT=5, SETTLE=6, ABORT=7.
- Default for every valve and pump line is 1 (closed). Each state opens only the valves listed below (drives them 0):
  - LOAD: `horiz_ctl`, `dead_end_ctl`.
  - LYSIS: `lysis_ctl`, `vertical_ctl`, `loop_exit_ctl`.
  - WASH: `wash_ctl`, `vertical_ctl`, `bead_vtl_ctl`, `bead_trap_ctl`.
  - ELUTE: `elute_ctl`, `vertical_ctl`, `bead_vtl_ctl`, `bead_trap_ctl`.
  - COLLECT: `bead_vtl_ctl`, `bead_trap_ctl`, `collection_ctl`.
- Pumping states (LYSIS to COLLECT) drive `{pump1,pump2,pump3}` through phases 0..5 = 110, 010, 011, 001, 101, 100.
  - Each phase lasts PUMP_PHASE_CYCLES cycles. A stroke ends after phase 5.
  - The phase index restarts at 0 on entry to every pumping state.
  - Outside pumping states, pumps are held at 111.
- Stage order is LOAD, LYSIS, WASH, ELUTE, COLLECT. Each stage is followed by SETTLE (all lines closed) for SETTLE_CYCLES cycles, then the next stage. After the final SETTLE the block returns to IDLE and pulses `done`.
- A stage whose stroke count or cycle count is 0 is skipped entirely, including its SETTLE.
- abort (any non-IDLE state) → ABORT: all lines closed for SETTLE_CYCLES, then IDLE with an `aborted` pulse. abort is ignored in IDLE and in ABORT.
- Counters: 16-bit cycle counter and 16-bit stroke counter. Parameters exceeding 16 bits are illegal.

## Timing
- Reset values: all valve/pump outputs 1; `busy`, `done`, `aborted` = 0; `state` = 0.
- start=1 in IDLE at edge N → state=LOAD and busy=1 from edge N+1. start outside IDLE is ignored.
- Stage durations:
  - LOAD lasts exactly LOAD_CYCLES cycles.
  - Pumping stage X lasts exactly X_STROKES × 6 × PUMP_PHASE_CYCLES cycles.
  - SETTLE and ABORT each last SETTLE_CYCLES cycles.
- Valve changes occur on the same edge as the state change; valve and pump outputs never toggle mid-phase.
- `done`/`aborted` are high in the first IDLE cycle; `busy` falls on the same edge.
- If abort and a stage completion occur in the same cycle, abort wins.
- start and abort together in IDLE: start is accepted.
- Reset mid-run: immediate (asynchronous) return to reset values.

## Configuration
- `MNACID_SEQ_STEP_EN` defined: adds input `step` (1 bit). At the end of every SETTLE the block holds all lines closed in SETTLE until `step`=1 is sampled, then advances on the next edge. abort remains honoured while holding.
- Not defined: no `step` port; SETTLE auto-advances.

## Test plan
- PUMP_PHASE_CYCLES=2, LOAD_CYCLES=4, all strokes=1, SETTLE_CYCLES=3, start pulse → state sequence 1,6,2,6,3,6,4,6,5,6,0; total busy = 4+4×12+5×3 = 67 cycles; done pulse at cycle 68 after start.
- In LYSIS with PUMP_PHASE_CYCLES=2 → pumps output 110,110,010,010,011,011,001,001,101,101,100,100, then 111 in SETTLE; `lysis_ctl`, `vertical_ctl`, `loop_exit_ctl`=0 and all other valve lines 1.
- abort asserted in the 3rd cycle of WASH → next edge state=7, all lines 1 for 3 cycles, then state=0 with aborted=1 for one cycle and done=0.
- WASH_STROKES=0 → LYSIS→SETTLE→ELUTE; state 3 is never seen.
- rst_n low for 1 cycle mid-ELUTE → all lines 1, busy=0, state=0 asynchronously; a subsequent start runs the full protocol from LOAD.
- With `MNACID_SEQ_STEP_EN`, step held 0 → state stays 6 after the first SETTLE; a step pulse → LYSIS on the following edge.
